// File: rtl/mult_pkg.sv
// Shared definitions for controllers that time-share the 2x2 multiplier.
package mult_pkg;

    localparam int MUL_W  = 2;
    localparam int PROD_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multiplier.sv
// Existing combinational unsigned 2x2 multiplier shared by the arbiter.
module multiplier (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] m
);

    assign m = a * b;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             found
);

    // Scan from the farthest candidate back to ptr so the closest one wins.
    always_comb begin
        int idx;
        idx      = 0;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Sequences one multiplication at a time from N_REQ requesters onto a single multiplier.
module mult_share_arbiter
    import mult_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int COUNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*MUL_W-1:0]        req_a,
    input  logic [N_REQ*MUL_W-1:0]        req_b,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [id_width(N_REQ)-1:0]    rsp_id,
    output logic [PROD_W-1:0]             rsp_m,
    output logic                          busy,
    output logic [COUNT_W-1:0]            op_count
);

    localparam int ID_W = id_width(N_REQ);

    state_t              state_q, state_d;
    logic [MUL_W-1:0]    op_a_q, op_a_d;
    logic [MUL_W-1:0]    op_b_q, op_b_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PROD_W-1:0]   rsp_m_q, rsp_m_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [COUNT_W-1:0]  op_count_q, op_count_d;

    logic [N_REQ-1:0]    grant;
    logic [ID_W-1:0]     grant_id;
    logic                grant_found;
    logic [PROD_W-1:0]   mul_m;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arbiter (
        .req      (req_valid),
        .ptr      (rr_ptr_q),
        .grant    (grant),
        .grant_id (grant_id),
        .found    (grant_found)
    );

    // Multiplier sees only the latched operands, so requester changes after accept are harmless.
    multiplier u_multiplier (
        .a (op_a_q),
        .b (op_b_q),
        .m (mul_m)
    );

    // Next-state, operand capture, response and pointer update.
    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        id_d        = id_q;
        rr_ptr_d    = rr_ptr_q;
        rsp_m_d     = rsp_m_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        op_count_d  = op_count_q;
        req_ready   = '0;
        unique case (state_q)
            IDLE: begin
                // The grant bit is only ever set on a valid requester, so ready implies handshake.
                if (grant_found) begin
                    req_ready = grant;
                    op_a_d    = req_a[int'(grant_id)*MUL_W +: MUL_W];
                    op_b_d    = req_b[int'(grant_id)*MUL_W +: MUL_W];
                    id_d      = grant_id;
                    state_d   = CALC;
                end
            end
            CALC: begin
                rsp_m_d     = mul_m;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + COUNT_W'(1);
                    rr_ptr_d    = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            id_q        <= '0;
            rr_ptr_q    <= '0;
            rsp_m_q     <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            id_q        <= id_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_m_q     <= rsp_m_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_m     = rsp_m_q;
    assign rsp_id    = rsp_id_q;
    assign op_count  = op_count_q;
    assign busy      = (state_q != IDLE);

endmodule
